cbd616_reload: RTL and testbench
================================

CBD616_RELOAD -- requirements
Module: cbd616_reload

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 CDN  input  1  asynchronous active-low clear; asserting it SHALL act immediately, and deasserting it SHALL take effect synchronously.
REQ-004 EN  input  1  count enable.
REQ-005 BI  input  1  borrow-in for cascading; tick = EN && BI.
REQ-006 LD  input  1  synchronous load strobe.
REQ-007 D  input  16  load value.
REQ-008 START  input  1  start-count strobe.
REQ-009 MODE  input  1  0 = one-shot, 1 = auto-reload; sampled only when START is accepted.
REQ-010 Q  output  16  current count, registered.
REQ-011 TC  output  1  terminal-count pulse, registered.
REQ-012 BO  output  1  borrow-out for cascading, combinational.
REQ-013 BUSY  output  1  high while the state is RUN.

Function
REQ-014 Internal state SHALL consist of:
- count register Q;
- reload register R (16 bits);
- mode register M;
- FSM with states IDLE, RUN and DONE.
REQ-015 Priority SHALL be CDN, then LD, then START, then tick; a lower-priority event in the same cycle SHALL be ignored.
REQ-016 LD in any state SHALL load R<=D and Q<=D, move the FSM to IDLE and clear TC the next cycle.
REQ-017 START in IDLE or DONE SHALL latch M<=MODE; the FSM SHALL go to RUN if Q!=0, else to DONE with TC=1 for one cycle.
REQ-018 START while in RUN SHALL be ignored.
REQ-019 In IDLE or DONE, ticks SHALL be ignored and Q SHALL hold.
REQ-020 In RUN, a tick with Q>1 SHALL set Q<=Q-1 with TC=0.
REQ-021 In RUN, a tick with Q==1 SHALL set Q<=0 and TC=1 for the next cycle; if M=0, the FSM SHALL go to DONE.
REQ-022 In RUN with M=1, a tick with Q==0 SHALL set Q<=R, giving a period of R+1 ticks per TC.
REQ-023 In RUN with M=1 and R==0, TC SHALL equal 1 after every tick.
REQ-024 TC SHALL be a single-cycle pulse, and SHALL be 0 in any cycle not described above.
REQ-025 Between ticks, Q SHALL hold, and TC SHALL return to 0 after one cycle.
REQ-026 Arithmetic SHALL be unsigned 16-bit; Q SHALL never underflow below 0 (no 0 -> FFFF wrap).
REQ-027 BO SHALL equal EN && BI && (Q==0) && (state==RUN) && !LD.
- BO is combinational, for chaining a higher-order stage's BI.
REQ-028 BUSY SHALL equal (state==RUN) and SHALL be registered-state derived, with no input paths.

Reset
REQ-029 While CDN=0, the block SHALL hold Q=0, R=0, M=0, TC=0, state=IDLE and BUSY=0; BO SHALL be 0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately with no TC pulse.
REQ-031 After CDN deassertion, the first accepted event SHALL be on the next rising CLK edge.

Structure
REQ-032 A shared package cbd616_pkg SHALL hold:
- the WIDTH=16 constant;
- the FSM state enum (IDLE, RUN, DONE).
REQ-033 The block SHALL be one flat module with no sub-module.
- The counter datapath and FSM are small enough that splitting them adds no value.
REQ-034 The RTL SHALL be synthesizable, with no latches and with all registers on the CLK/CDN async-clear template.

Verification
REQ-035 One-shot countdown:
- Stimulus: LD with D=3, then START with MODE=0, then EN=BI=1 continuous.
- Required response: Q = 3,2,1,0; TC high exactly in the cycle Q first reads 0; state goes to DONE; Q stays 0; BUSY falls.
REQ-036 Auto-reload:
- Stimulus: D=2, MODE=1, ticks continuous.
- Required response: Q = 2,1,0,2,1,0...; TC every 3rd cycle; BO high on cycles with Q=0.
REQ-037 Tick gating:
- Stimulus: D=5, RUN, BI toggling 1,0,1,0.
- Required response: Q decrements only on BI=1 cycles; TC stays 0 until Q reaches 0.
REQ-038 Priority:
- Stimulus: LD (D=7) and START asserted together while in RUN at Q=4.
- Required response: Q=7, state IDLE, TC=0; START ignored.
REQ-039 Zero start and R=0 reload:
- Stimulus A: LD with D=0, then START.
- Required response A: state DONE and a single TC pulse.
- Stimulus B: D=0, MODE=1, START taken.
- Required response B: state DONE, since Q==0 at START.
REQ-040 Async reset:
- Stimulus: CDN pulsed low between clock edges mid-RUN at Q=0x1234.
- Required response: Q=0, TC=0, BUSY=0 before the next edge; a subsequent tick has no effect until LD/START.

Source files
------------

// File: rtl/cbd616_pkg.sv
// Shared constants and FSM encoding for the cbd616 reloadable down-counter.
package cbd616_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Decrement that sticks at zero instead of wrapping to all-ones.
    function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

endpackage

// File: rtl/cbd616_reload.sv
// Cascadable 16-bit down-counter with load, one-shot/auto-reload modes,
// registered terminal-count pulse and combinational borrow-out.
module cbd616_reload
    import cbd616_pkg::*;
(
    input  logic             CLK,
    input  logic             CDN,
    input  logic             EN,
    input  logic             BI,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic             MODE,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BO,
    output logic             BUSY
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             m_q, m_d;
    logic             tc_q, tc_d;
    logic             tick;

    assign tick = EN && BI;

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            m_q     <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            m_q     <= m_d;
            tc_q    <= tc_d;
        end
    end

    // LD beats START beats tick; START is only accepted outside RUN.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        m_d     = m_q;
        tc_d    = 1'b0;
        if (LD) begin
            q_d     = D;
            r_d     = D;
            state_d = ST_IDLE;
        end else if (START && (state_q != ST_RUN)) begin
            m_d = MODE;
            if (q_q != '0) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_DONE;
                tc_d    = 1'b1;
            end
        end else if (tick && (state_q == ST_RUN)) begin
            if (q_q == '0) begin
                // Only reachable in auto-reload: the zero cycle is part of the period.
                if (m_q) begin
                    q_d  = r_q;
                    tc_d = (r_q == '0);
                end
            end else begin
                q_d = dec_sat(q_q);
                if (q_q == WIDTH'(1)) begin
                    tc_d = 1'b1;
                    if (!m_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
        end
    end

    assign Q    = q_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == ST_RUN);
    assign BO   = tick && (q_q == '0) && (state_q == ST_RUN) && !LD;

endmodule

// File: tb/tb_cbd616_reload.sv
// Self-checking bench for cbd616_reload: directed table, corner sequences and
// randomized traffic compared against a behavioural model.
module tb_cbd616_reload;

    logic        CLK = 1'b0;
    logic        CDN, EN, BI, LD, START, MODE;
    logic [15:0] D, Q;
    logic        TC, BO, BUSY;

    int errors = 0;
    int checks = 0;

    cbd616_reload dut (
        .CLK(CLK), .CDN(CDN), .EN(EN), .BI(BI), .LD(LD), .D(D),
        .START(START), .MODE(MODE), .Q(Q), .TC(TC), .BO(BO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: phase 0 idle, 1 counting, 2 finished.
    logic [15:0] mq, mr;
    logic        mm, mtc;
    int          mph;

    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic        start, mode, en, bi;
        logic [15:0] eq;
        logic        etc, ebusy, ebo;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq = 16'd0; mr = 16'd0; mm = 1'b0; mtc = 1'b0; mph = 0;
    endtask

    function automatic logic model_bo(input logic ld, input logic en, input logic bi);
        return en && bi && !ld && (mph == 1) && (mq == 16'd0);
    endfunction

    task automatic model_step(input logic ld, input logic [15:0] d, input logic start,
                              input logic mode, input logic en, input logic bi);
        mtc = 1'b0;
        if (ld) begin
            mq = d; mr = d; mph = 0;
        end else if (start && mph != 1) begin
            mm = mode;
            if (mq != 0) mph = 1;
            else begin mph = 2; mtc = 1'b1; end
        end else if (en && bi && mph == 1) begin
            if (mq == 0) begin
                if (mm) begin mq = mr; mtc = (mr == 0); end
            end else begin
                mq = mq - 16'd1;
                if (mq == 0) begin
                    mtc = 1'b1;
                    if (!mm) mph = 2;
                end
            end
        end
    endtask

    task automatic cycle(input logic ld, input logic [15:0] d, input logic start,
                         input logic mode, input logic en, input logic bi, output logic bo_s);
        @(negedge CLK);
        LD = ld; D = d; START = start; MODE = mode; EN = en; BI = bi;
        #1;
        bo_s = BO;
        chk("bo", 32'(BO), 32'(model_bo(ld, en, bi)));
        @(posedge CLK);
        #1;
        model_step(ld, d, start, mode, en, bi);
        chk("q", 32'(Q), 32'(mq));
        chk("tc", 32'(TC), 32'(mtc));
        chk("busy", 32'(BUSY), 32'(mph == 1));
    endtask

    function automatic vec_t mk(input logic ld, input logic [15:0] d, input logic start,
                                input logic mode, input logic en, input logic bi,
                                input logic [15:0] eq, input logic etc,
                                input logic ebusy, input logic ebo);
        vec_t v;
        v.ld = ld; v.d = d; v.start = start; v.mode = mode; v.en = en; v.bi = bi;
        v.eq = eq; v.etc = etc; v.ebusy = ebusy; v.ebo = ebo;
        return v;
    endfunction

    initial begin
        logic bo_s;
        int   tc_cnt;
        //            ld d     st md en bi   Q     tc busy bo
        tbl[0]  = mk(1, 16'd3, 0, 0, 0, 0, 16'd3, 0, 0, 0);
        tbl[1]  = mk(0, 16'd0, 1, 0, 1, 1, 16'd3, 0, 1, 0);
        tbl[2]  = mk(0, 16'd0, 0, 0, 1, 1, 16'd2, 0, 1, 0);
        tbl[3]  = mk(0, 16'd0, 0, 0, 1, 1, 16'd1, 0, 1, 0);
        tbl[4]  = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 1, 0, 0);
        tbl[5]  = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 0, 0, 0);
        tbl[6]  = mk(0, 16'd0, 1, 0, 1, 1, 16'd0, 1, 0, 0);
        tbl[7]  = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 0, 0, 0);
        tbl[8]  = mk(1, 16'd2, 0, 0, 0, 0, 16'd2, 0, 0, 0);
        tbl[9]  = mk(0, 16'd0, 1, 1, 1, 1, 16'd2, 0, 1, 0);
        tbl[10] = mk(0, 16'd0, 0, 0, 1, 1, 16'd1, 0, 1, 0);
        tbl[11] = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 1, 1, 0);
        tbl[12] = mk(0, 16'd0, 0, 0, 1, 1, 16'd2, 0, 1, 1);
        tbl[13] = mk(0, 16'd0, 0, 0, 1, 1, 16'd1, 0, 1, 0);
        tbl[14] = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 1, 1, 0);
        tbl[15] = mk(1, 16'd0, 0, 0, 1, 1, 16'd0, 0, 0, 0);
        tbl[16] = mk(0, 16'd0, 1, 1, 0, 0, 16'd0, 1, 0, 0);
        tbl[17] = mk(0, 16'd0, 0, 0, 1, 1, 16'd0, 0, 0, 0);

        CDN = 1'b0; EN = 1'b1; BI = 1'b1; LD = 1'b0; START = 1'b0; MODE = 1'b0; D = 16'hFFFF;
        model_reset();
        #12;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_tc", 32'(TC), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_bo", 32'(BO), 32'd0);
        @(negedge CLK);
        CDN = 1'b1;

        // Directed table: one-shot, auto-reload, zero start.
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].ld, tbl[i].d, tbl[i].start, tbl[i].mode, tbl[i].en, tbl[i].bi, bo_s);
            chk($sformatf("tbl%0d_q", i), 32'(Q), 32'(tbl[i].eq));
            chk($sformatf("tbl%0d_tc", i), 32'(TC), 32'(tbl[i].etc));
            chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].ebusy));
            chk($sformatf("tbl%0d_bo", i), 32'(bo_s), 32'(tbl[i].ebo));
        end

        // Tick gating: only BI=1 cycles decrement.
        cycle(1, 16'd5, 0, 0, 0, 0, bo_s);
        cycle(0, 16'd0, 1, 0, 1, 0, bo_s);
        tc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 16'd0, 0, 0, 1, (i % 2 == 0), bo_s);
            if (TC) tc_cnt++;
            if (i == 5) chk("gate_q_mid", 32'(Q), 32'd2);
        end
        chk("gate_tc_count", 32'(tc_cnt), 32'd1);
        chk("gate_q_end", 32'(Q), 32'd0);

        // Priority: LD with START while running at Q=4.
        cycle(1, 16'd9, 0, 0, 0, 0, bo_s);
        cycle(0, 16'd0, 1, 0, 0, 0, bo_s);
        for (int i = 0; i < 5; i++) cycle(0, 16'd0, 0, 0, 1, 1, bo_s);
        chk("prio_pre_q", 32'(Q), 32'd4);
        cycle(1, 16'd7, 1, 1, 1, 1, bo_s);
        chk("prio_q", 32'(Q), 32'd7);
        chk("prio_tc", 32'(TC), 32'd0);
        chk("prio_busy", 32'(BUSY), 32'd0);
        cycle(0, 16'd0, 0, 0, 1, 1, bo_s);
        chk("prio_hold_q", 32'(Q), 32'd7);

        // Async clear between edges while running at 0x1234.
        cycle(1, 16'h1235, 0, 0, 0, 0, bo_s);
        cycle(0, 16'd0, 1, 0, 0, 0, bo_s);
        cycle(0, 16'd0, 0, 0, 1, 1, bo_s);
        chk("ar_pre_q", 32'(Q), 32'h1234);
        @(negedge CLK);
        LD = 1'b0; START = 1'b0; EN = 1'b1; BI = 1'b1;
        #2 CDN = 1'b0;
        #1;
        chk("ar_q", 32'(Q), 32'd0);
        chk("ar_tc", 32'(TC), 32'd0);
        chk("ar_busy", 32'(BUSY), 32'd0);
        chk("ar_bo", 32'(BO), 32'd0);
        #1 CDN = 1'b1;
        model_reset();
        cycle(0, 16'd0, 0, 0, 1, 1, bo_s);
        chk("ar_after_q", 32'(Q), 32'd0);
        chk("ar_after_tc", 32'(TC), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic        r_ld, r_st, r_md, r_en, r_bi;
            logic [15:0] r_d;
            if ($urandom_range(0, 199) == 0) begin
                @(negedge CLK);
                #2 CDN = 1'b0;
                #1;
                chk("rnd_rst_q", 32'(Q), 32'd0);
                chk("rnd_rst_busy", 32'(BUSY), 32'd0);
                #1 CDN = 1'b1;
                model_reset();
            end
            r_ld = ($urandom_range(0, 19) == 0);
            r_st = ($urandom_range(0, 9) == 0);
            r_md = 1'($urandom_range(0, 1));
            r_en = ($urandom_range(0, 3) != 0);
            r_bi = ($urandom_range(0, 3) != 0);
            r_d  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            cycle(r_ld, r_d, r_st, r_md, r_en, r_bi, bo_s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
